spi_ram_param: RTL and testbench

//  Parametrised command/data RAM behind the SPI slave shift register. Each rx_valid word carries a
//  2-bit opcode plus payload: write address, write data, read address, read data. A read-data request

---
 rtl/spi_ram_param.sv | 162 ++++++++++++++++
 tb/tb_spi_ram_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_param.sv
// rtl/spi_ram_param.sv - parametrised command/data RAM behind an SPI slave shifter
//
// Each rx_valid word is {opcode[1:0], payload[DATA_WIDTH-1:0]}:
//   00 set write address, 01 write data, 10 set read address (arms a read),
//   11 read data (answered one cycle later on dout with a tx_valid pulse).
// Optional build macro: SPI_RAM_AUTOINC_EN
//   Write data and read data post-increment their address (wrapping at MEM_DEPTH-1),
//   and a read keeps the FSM armed for burst reads.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   din       in   [DATA_WIDTH+1:DATA_WIDTH] opcode, [DATA_WIDTH-1:0] payload
//   rx_valid  in   din valid this cycle
//   dout      out  read data, holds last value when tx_valid=0
//   tx_valid  out  one-cycle strobe: dout carries a fresh read
//   seq_err   out  one-cycle strobe: read with nothing armed, or address out of range
module spi_ram_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  seq_err
);

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // One extra bit so the range check also works when MEM_DEPTH == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ARMED = 2'd1,
    RESP     = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    seq_err_q, seq_err_d;
  logic                    mem_we;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic [1:0]              opcode;
  logic [DATA_WIDTH-1:0]   payload;
  logic [ADDR_WIDTH-1:0]   payload_addr;
  logic                    wr_in_range;
  logic                    rd_in_range;
  logic                    armed;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign opcode       = din[DATA_WIDTH+1 -: 2];
  assign payload      = din[DATA_WIDTH-1:0];
  assign payload_addr = din[ADDR_WIDTH-1:0];
  assign wr_in_range  = {1'b0, wr_addr_q} < DEPTH_W;
  assign rd_in_range  = {1'b0, rd_addr_q} < DEPTH_W;
  assign rd_word      = mem[rd_addr_q];

  // In burst mode the response cycle still counts as armed, so back-to-back
  // read-data commands stream consecutive words.
  assign armed = (state_q == RD_ARMED) || (AUTOINC && (state_q == RESP));

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    seq_err_d  = 1'b0;
    mem_we     = 1'b0;

    // RESP lasts exactly one cycle whether or not a command arrives.
    if (state_q == RESP) begin
      state_d = AUTOINC ? RD_ARMED : IDLE;
    end

    if (rx_valid) begin
      unique case (opcode)
        OP_WR_ADDR: begin
          wr_addr_d = payload_addr;
        end
        OP_WR_DATA: begin
          if (wr_in_range) begin
            mem_we = 1'b1;
            if (AUTOINC) wr_addr_d = addr_inc(wr_addr_q);
          end
        end
        OP_RD_ADDR: begin
          rd_addr_d = payload_addr;
          state_d   = RD_ARMED;
        end
        OP_RD_DATA: begin
          if (!armed) begin
            seq_err_d = 1'b1;
          end else if (!rd_in_range) begin
            seq_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            dout_d     = rd_word;
            tx_valid_d = 1'b1;
            state_d    = RESP;
            if (AUTOINC) rd_addr_d = addr_inc(rd_addr_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      seq_err_q  <= seq_err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_q] <= payload;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_spi_ram_param.sv
// tb/tb_spi_ram_param.sv - directed self-checking bench for spi_ram_param
module tb_spi_ram_param;

  localparam logic [1:0] WA = 2'b00;
  localparam logic [1:0] WD = 2'b01;
  localparam logic [1:0] RA = 2'b10;
  localparam logic [1:0] RD = 2'b11;

`ifdef SPI_RAM_AUTOINC_EN
  localparam logic [7:0] ADDR_AFTER_WR55 = 8'h56;
`else
  localparam logic [7:0] ADDR_AFTER_WR55 = 8'h55;
`endif

  logic       clk;
  logic       rst_n;
  logic [9:0] din, din2;
  logic       rx_valid, rx_valid2;
  logic [7:0] dout, dout2;
  logic       tx_valid, tx_valid2;
  logic       seq_err, seq_err2;

  int checks = 0;
  int errors = 0;

  spi_ram_param dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .seq_err  (seq_err)
  );

  spi_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200)) dut200 (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din2),
    .rx_valid (rx_valid2),
    .dout     (dout2),
    .tx_valid (tx_valid2),
    .seq_err  (seq_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one command for one posedge and returns at
  // the following negedge, where the response is visible.
  task automatic send(input bit sel, input logic [1:0] op, input logic [7:0] pl);
    if (!sel) begin
      din = {op, pl};
      rx_valid = 1'b1;
    end else begin
      din2 = {op, pl};
      rx_valid2 = 1'b1;
    end
    @(negedge clk);
    rx_valid  = 1'b0;
    rx_valid2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    din = '0; din2 = '0;
    rx_valid = 1'b0; rx_valid2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dout", {8'h0, dout}, 16'h0000);
    chk("rst_tx_valid", {15'h0, tx_valid}, 16'h0000);
    chk("rst_seq_err", {15'h0, seq_err}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Read data straight after reset: nothing armed.
    send(0, RD, 8'h00);
    chk("t2_seq_err", {15'h0, seq_err}, 16'h0001);
    chk("t2_tx_valid", {15'h0, tx_valid}, 16'h0000);
    chk("t2_dout", {8'h0, dout}, 16'h0000);
    @(negedge clk);
    chk("t2_seq_err_drop", {15'h0, seq_err}, 16'h0000);

    // Basic write then read.
    send(0, WA, 8'h55);
    send(0, WD, 8'h99);
    send(0, RA, 8'h55);
    send(0, RD, 8'h00);
    chk("t1_tx_valid", {15'h0, tx_valid}, 16'h0001);
    chk("t1_dout", {8'h0, dout}, 16'h0099);
    @(negedge clk);
    chk("t1_tx_pulse_end", {15'h0, tx_valid}, 16'h0000);
    chk("t1_dout_hold", {8'h0, dout}, 16'h0099);

`ifndef SPI_RAM_AUTOINC_EN
    send(0, RD, 8'h00);
    chk("rd_again_seq_err", {15'h0, seq_err}, 16'h0001);
    chk("rd_again_tx_valid", {15'h0, tx_valid}, 16'h0000);
    chk("rd_again_dout", {8'h0, dout}, 16'h0099);
`endif

    // rx_valid low: din must be ignored.
    din = 10'b11_1111_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_idle_tx_valid", {15'h0, tx_valid}, 16'h0000);
      chk("t3_idle_seq_err", {15'h0, seq_err}, 16'h0000);
    end
    din = {WD, 8'h77};
    @(negedge clk);
    din = {WA, 8'h10};
    @(negedge clk);
    send(0, RA, 8'h55);
    send(0, RD, 8'h00);
    chk("t3_no_write", {8'h0, dout}, 16'h0099);
    send(0, WD, 8'h5A);
    send(0, RA, ADDR_AFTER_WR55);
    send(0, RD, 8'h00);
    chk("t3_wr_addr_kept", {8'h0, dout}, 16'h005A);

    // Address boundaries and re-arming.
    send(0, WA, 8'h00);
    send(0, WD, 8'h11);
    send(0, WA, 8'hFF);
    send(0, WD, 8'hEE);
    send(0, RA, 8'h00);
    send(0, RD, 8'h00);
    chk("bnd_addr00", {8'h0, dout}, 16'h0011);
    send(0, RA, 8'h00);
    send(0, RA, 8'hFF);
    send(0, RD, 8'h00);
    chk("rearm_addrFF", {8'h0, dout}, 16'h00EE);
    chk("rearm_tx_valid", {15'h0, tx_valid}, 16'h0001);

    // New read address accepted during the response cycle.
    send(0, RA, 8'h00);
    chk("resp_ra_tx_drop", {15'h0, tx_valid}, 16'h0000);
    send(0, RD, 8'h00);
    chk("resp_ra_dout", {8'h0, dout}, 16'h0011);
`ifndef SPI_RAM_AUTOINC_EN
    send(0, RD, 8'h00);
    chk("resp_rd_seq_err", {15'h0, seq_err}, 16'h0001);
    chk("resp_rd_tx_valid", {15'h0, tx_valid}, 16'h0000);
    chk("resp_rd_dout", {8'h0, dout}, 16'h0011);
`endif

    // Reset asserted mid-cycle while armed.
    send(0, RA, 8'h55);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_tx_valid", {15'h0, tx_valid}, 16'h0000);
    chk("t4_async_dout", {8'h0, dout}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, RD, 8'h00);
    chk("t4_seq_err", {15'h0, seq_err}, 16'h0001);
    chk("t4_tx_valid", {15'h0, tx_valid}, 16'h0000);
    send(0, RA, ADDR_AFTER_WR55);
    send(0, RD, 8'h00);
    chk("t4_mem_kept", {8'h0, dout}, 16'h005A);

    // Two data writes after WR_ADDR 0xFF.
    send(0, WA, 8'hFF);
    send(0, WD, 8'hA1);
    send(0, WD, 8'hB2);
`ifdef SPI_RAM_AUTOINC_EN
    send(0, RA, 8'hFF);
    send(0, RD, 8'h00);
    chk("t5_burst0", {8'h0, dout}, 16'h00A1);
    send(0, RD, 8'h00);
    chk("t5_burst1", {8'h0, dout}, 16'h00B2);
    chk("t5_burst1_tx", {15'h0, tx_valid}, 16'h0001);
`else
    send(0, RA, 8'hFF);
    send(0, RD, 8'h00);
    chk("t5_overwrite", {8'h0, dout}, 16'h00B2);
    send(0, RA, 8'h00);
    send(0, RD, 8'h00);
    chk("t5_addr00_kept", {8'h0, dout}, 16'h0011);
`endif

    // Shallow memory: 200 words, addresses 0xC8 and above are out of range.
    send(1, WA, 8'hC7);
    send(1, WD, 8'h44);
    send(1, WA, 8'h00);
    send(1, WD, 8'h55);
    send(1, WA, 8'hC8);
    send(1, WD, 8'h33);
    send(1, WA, 8'hFF);
    send(1, WD, 8'h66);
    send(1, RA, 8'hC7);
    send(1, RD, 8'h00);
    chk("t6_last_word", {8'h0, dout2}, 16'h0044);
    chk("t6_last_tx", {15'h0, tx_valid2}, 16'h0001);
    send(1, RA, 8'h00);
    send(1, RD, 8'h00);
    chk("t6_word0_kept", {8'h0, dout2}, 16'h0055);
    send(1, RA, 8'hC8);
    send(1, RD, 8'h00);
    chk("t6_oor_seq_err", {15'h0, seq_err2}, 16'h0001);
    chk("t6_oor_tx_valid", {15'h0, tx_valid2}, 16'h0000);
    chk("t6_oor_dout", {8'h0, dout2}, 16'h0055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
